// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter, LSB first, 1 start / 1 stop bit.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_MAX  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_end;
    logic                 last_bit;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign bit_end  = (baud_cnt == BAUD_MAX);
    assign last_bit = (bit_cnt == BIT_MAX);
    assign accept   = tx_valid && (state == IDLE);

    // State register; reset wins over any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each non-idle state lasts whole bit periods.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Baud counter: free-runs within a bit, parked at 0 while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Bit counter: indexes data bits, cleared outside DATA.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
        end
    end

    // Shift register: load on accept, shift right at each data bit end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= tx_data;
        end else if (state == DATA && bit_end) begin
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity captured once from the accepted byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^tx_data;
        end
    end
`endif

    // Moore outputs decoded from registered state only.
    always_comb begin
        tx_serial  = 1'b1;
        tx_ready   = 1'b0;
        tx_busy    = 1'b1;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
            end
            START: begin
                tx_serial = 1'b0;
            end
            DATA: begin
                tx_serial = shift_reg[0];
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_serial = parity_bit;
            end
`endif
            STOP: begin
                frame_done = bit_end;
            end
            default: begin
                tx_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed plus random frames checked per cycle
// against a frame-level model of the serial line.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int FL = NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          frame_done;

    int   checks = 0;
    int   errors = 0;
    logic cap [0:FL+1];
    int   done_at;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_serial(tx_serial),
        .tx_busy(tx_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level during cycle k (1-based) after the accept edge.
    function automatic logic exp_bit(input logic [DB-1:0] d, input int k);
        int b;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= DB) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_serial"}, 32'(tx_serial), 1);
        check({tag, "_ready"}, 32'(tx_ready), 1);
        check({tag, "_busy"}, 32'(tx_busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
    endtask

    // Called at a negedge; sends d and checks every frame cycle.
    task automatic run_frame(input logic [DB-1:0] d, input bit keep,
                             input int inject, input int abort_at);
        int w;
        tx_valid = 1'b1;
        tx_data  = d;
        w = 0;
        while (tx_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", 32'(tx_ready), 1);
        @(posedge clk);
        done_at = -1;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tx_valid = keep;
                tx_data  = keep ? d : DB'($urandom);
            end
            cap[k] = tx_serial;
            if (frame_done === 1'b1 && done_at < 0) done_at = k;
            check("serial", 32'(tx_serial), 32'(exp_bit(d, k)));
            check("busy", 32'(tx_busy), 1);
            check("ready_in_frame", 32'(tx_ready), 0);
            check("frame_done", 32'(frame_done), 32'(k == FL));
            if (inject > 0 && k == inject) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (inject > 0 && k == inject + 2) begin
                tx_valid = keep;
                tx_data  = d;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_idle("abort");
                rst_n    = 1'b1;
                tx_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_idle("post_frame");
        check("done_cycle", 32'(done_at), 32'(FL));
    endtask

    initial begin
        logic [9:0]    a5_exp;
        logic [DB-1:0] rd;
        bit            kp;

        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        rst_n = 1'b1;
        run_frame(8'h55, 1'b0, 0, 0);

`ifndef UART_TX_PARITY_EN
        a5_exp = 10'b1101001010;
        run_frame(8'hA5, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("a5_sequence", 32'(cap[1 + CPB * i]), 32'(a5_exp[i]));
        end
`else
        a5_exp = '0;
        run_frame(8'h07, 1'b0, 0, 0);
        check("parity_bit", 32'(cap[(DB + 1) * CPB + 1]), 1);
        check("data_bit7", 32'(cap[DB * CPB + 1]), 0);
`endif

        run_frame(8'h00, 1'b1, 0, 0);
        run_frame(8'hFF, 1'b0, 0, 0);
        for (int i = 1; i <= DB; i++) begin
            check("ff_data_bit", 32'(cap[i * CPB + 1]), 1);
        end

        run_frame(8'h5A, 1'b0, 10, 0);
        repeat (3 * CPB) begin
            @(negedge clk);
            check_idle("no_3c");
        end

        run_frame(8'h0F, 1'b0, 0, 18);
        @(negedge clk);
        check_idle("after_abort");
        run_frame(8'h81, 1'b0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            rd = DB'($urandom);
            kp = 1'($urandom_range(0, 1));
            run_frame(rd, kp, 0, 0);
            if (!kp) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check_idle("rand_gap");
                end
            end
        end
        tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide UART transmitter: takes a parallel byte over a valid/ready handshake and drives it LSB-first on a single serial line.
- Frame: 1 start bit, DATA_BITS data bits, 1 stop bit.
- Pairs with the team's UART receive path as the outbound end of the same serial link. Sits between the seminar test core and the board TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2 to 65535.
- DATA_BITS, 8, data bits per frame; legal range 5 to 8.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_serial  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - State goes to IDLE; bit counter and baud counter go to 0.
  - tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0.
  - Reset takes priority over everything, including mid-frame. A partial frame is abandoned and the line returns high on the next edge.
- Handshake:
  - A transfer occurs on a clk edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge.
  - tx_ready=1 only in IDLE. tx_ready is registered and does not depend combinationally on tx_valid.
  - tx_valid held high while tx_ready=0 is ignored. The source must hold tx_data stable until accepted.
- FSM states: IDLE, START, DATA, (PARITY when the option is enabled), STOP.
  - IDLE -> START on an accepted transfer. On the next cycle tx_serial=0, tx_busy=1, tx_ready=0.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift_reg[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After DATA_BITS bits go to STOP, or to PARITY when enabled.
  - STOP: drive 1 for CLKS_PER_BIT cycles. frame_done=1 during the final cycle. Then go to IDLE, with tx_ready=1 and tx_busy=0 on the following cycle.
- Timing:
  - Latency from accept edge to the start-bit falling edge is 1 cycle.
  - Frame length is (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames: if tx_valid is held high, the next accept happens on the first IDLE cycle. The inter-frame gap is exactly 1 idle cycle at tx_serial=1.
- Counters:
  - Baud counter is 16 bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit counter is 3 bits, counts 0..DATA_BITS-1.
  - No counter is allowed to overflow past its terminal value.
- Simultaneous events: tx_valid rising on the same edge the FSM returns to IDLE is not accepted, because tx_ready is still 0 on that edge. It is accepted on the next edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA and drives the even-parity bit (XOR of the latched data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: the PARITY state and parity logic are absent, and the frame carries no parity bit.

Test Plan:
- Reset hold: rst_n=0 for 5 cycles with tx_valid=1 -> tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0 throughout. No frame starts until one cycle after rst_n=1.
- Single byte, CLKS_PER_BIT=4: send 0xA5 -> tx_serial sequence at 4-cycle spacing is 0,1,0,1,0,0,1,0,1,1. frame_done pulses once at cycle 40 after accept. tx_ready returns 1 at cycle 41.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly 1 idle-high cycle. The second frame's data bits are all 1.
- Ignored request: pulse tx_valid with 0x3C mid-frame while tx_ready=0 -> no effect. The current frame completes unaltered and 0x3C is never sent.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x0F -> tx_serial=1 on the next edge and state is IDLE. A following byte 0x81 is sent correctly.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit=1 between data bit 7 and stop. Frame length is 44 cycles at CLKS_PER_BIT=4.
